// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes, FSM states and decode
// helpers.
package muldiv_unit_pkg;

    localparam int unsigned Width = 32;

    typedef enum logic [1:0] {
        MdMult  = 2'b00,
        MdMultu = 2'b01,
        MdDiv   = 2'b10,
        MdDivu  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MdIdle = 2'b00,
        MdRun  = 2'b01,
        MdFix  = 2'b10,
        MdDone = 2'b11
    } md_state_e;

    function automatic logic md_is_signed(md_op_e op);
        return op inside {MdMult, MdDiv};
    endfunction

    function automatic logic md_is_div(md_op_e op);
        return op inside {MdDiv, MdDivu};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the ALU HI/LO path (master) and the multiply/divide unit
// (slave).
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = muldiv_unit_pkg::Width
);
    logic                       start;
    muldiv_unit_pkg::md_op_e    op;
    logic [WIDTH-1:0]           a;
    logic [WIDTH-1:0]           b;
    logic                       busy;
    logic                       done;
    logic [WIDTH-1:0]           hi;
    logic [WIDTH-1:0]           lo;
    logic                       div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide: shift-add multiply or restoring divide over a shared 64-bit
// accumulator, 33 cycles from accepted start to done, results held in HI/LO.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = Width
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  md
);

    md_state_e            state_q;
    logic [4:0]           cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 is_div_q;
    logic                 res_neg_q;
    logic                 a_neg_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 div_zero_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       prem;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_next;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic                 dz;

    always_comb begin
        a_neg    = md_is_signed(md.op) && md.a[WIDTH-1];
        b_neg    = md_is_signed(md.op) && md.b[WIDTH-1];
        a_mag    = a_neg ? -md.a : md.a;
        b_mag    = b_neg ? -md.b : md.b;

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        // When the subtract succeeds the true remainder is below the divisor, so 32 bits suffice.
        prem     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = prem >= {1'b0, opnd_q};
        rem_next = div_ge ? (prem[WIDTH-1:0] - opnd_q) : prem[WIDTH-1:0];

        acc_next = is_div_q ? {rem_next, acc_q[WIDTH-2:0], div_ge}
                            : {mul_sum, acc_q[WIDTH-1:1]};

        prod     = res_neg_q ? -acc_q : acc_q;
        quot     = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        // With a zero divisor every step subtracts nothing, leaving |a| in the upper half.
        rem      = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        dz       = is_div_q && (opnd_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MdIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            a_neg_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                MdIdle: begin
                    if (md.start) begin
                        is_div_q  <= md_is_div(md.op);
                        acc_q     <= {{WIDTH{1'b0}}, a_mag};
                        opnd_q    <= b_mag;
                        a_neg_q   <= a_neg;
                        res_neg_q <= a_neg ^ b_neg;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= MdRun;
                    end
                end
                MdRun: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= MdFix;
                    end
                end
                MdFix: begin
                    if (is_div_q) begin
                        hi_q <= rem;
                        lo_q <= dz ? '1 : quot;
                    end else begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
                    div_zero_q <= dz;
                    done_q     <= 1'b1;
                    state_q    <= MdDone;
                end
                MdDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= MdIdle;
                end
                default: state_q <= MdIdle;
            endcase
        end
    end

    assign md.busy     = busy_q;
    assign md.done     = done_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of operations with hand-computed HI/LO, plus
// restart-ignored and mid-operation reset sequences.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    vec_t vecs[12];

    muldiv_unit_if #(.WIDTH(32)) md();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (md.done) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op and follow it to completion; optionally re-pulse start mid-run.
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz, input int restart_at);
        int n;
        int dc0;
        @(negedge clk);
        md.op    = op;
        md.a     = a;
        md.b     = b;
        md.start = 1'b1;
        dc0      = done_cnt;
        @(negedge clk);
        md.start = 1'b0;
        md.a     = $urandom;
        md.b     = $urandom;
        md.op    = MdDiv;
        n        = 0;
        check({tag, "_busy_e0"}, {63'b0, md.busy}, 64'd1);
        while (!md.done && n < 60) begin
            @(negedge clk);
            n++;
            md.start = (n == restart_at);
            if (n == restart_at) begin
                md.op = MdMult;
                md.a  = 32'd7;
                md.b  = 32'd7;
            end
        end
        md.start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_hi"}, {32'b0, md.hi}, {32'b0, exp_hi});
        check({tag, "_lo"}, {32'b0, md.lo}, {32'b0, exp_lo});
        check({tag, "_dz"}, {63'b0, md.div_zero}, {63'b0, exp_dz});
        @(negedge clk);
        check({tag, "_done_fall"}, {63'b0, md.done}, 64'd0);
        check({tag, "_busy_fall"}, {63'b0, md.busy}, 64'd0);
        @(negedge clk);
        check({tag, "_hold_lo"}, {32'b0, md.lo}, {32'b0, exp_lo});
        check({tag, "_one_done"}, 64'(done_cnt - dc0), 64'd1);
    endtask

    initial begin
        int dc0;
        md.start = 1'b0;
        md.op    = MdMultu;
        md.a     = '0;
        md.b     = '0;

        vecs[0]  = '{MdMultu, 32'd10,         32'd10,         32'h0,        32'd100,      1'b0};
        vecs[1]  = '{MdMult,  32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{MdDivu,  32'd100,        32'd7,          32'd2,        32'd14,       1'b0};
        vecs[3]  = '{MdDiv,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{MdDivu,  32'd5,          32'd0,          32'd5,        32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{MdMultu, 32'd2,          32'd3,          32'h0,        32'd6,        1'b0};
        vecs[6]  = '{MdMultu, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[7]  = '{MdMult,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,        32'h8000_0000, 1'b0};
        vecs[8]  = '{MdDiv,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0,        32'h8000_0000, 1'b0};
        vecs[9]  = '{MdDiv,   32'd7,          32'hFFFF_FFFE,  32'd1,        32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{MdDiv,   32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
        vecs[11] = '{MdMult,  32'hFFFF_FFFB,  32'hFFFF_FFFA,  32'h0,        32'd30,       1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, md.busy}, 64'd0);
        check("rst_done", {63'b0, md.done}, 64'd0);
        check("rst_hi", {32'b0, md.hi}, 64'd0);
        check("rst_lo", {32'b0, md.lo}, 64'd0);
        check("rst_dz", {63'b0, md.div_zero}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, -1);
        end

        run_op("restart", MdMultu, 32'd10, 32'd10, 32'h0, 32'd100, 1'b0, 5);

        // Leave nonzero HI/LO behind, then abort a divide with reset.
        run_op("pre_rst", MdMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1);
        @(negedge clk);
        md.op    = MdDivu;
        md.a     = 32'd100;
        md.b     = 32'd7;
        md.start = 1'b1;
        dc0      = done_cnt;
        @(negedge clk);
        md.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, md.busy}, 64'd0);
        check("abort_hi", {32'b0, md.hi}, 64'd0);
        check("abort_lo", {32'b0, md.lo}, 64'd0);
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - dc0), 64'd0);
        rst_n = 1'b1;
        run_op("post_rst", MdMultu, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit, the responder to the ALU's HI/LO request path in the MIPS core. It accepts one operation per `start` pulse, runs a fixed-latency shift-add multiply or restoring divide, and writes the 64-bit result to the HI/LO registers. It signals completion with a one-cycle `done` pulse. Consumers hold off on HI/LO reads while `busy` is high.

## Interface
- `WIDTH`, 32: operand width; only 32 is supported.
- `clk` input 1: clock, all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request strobe, sampled only in IDLE.
- `op` input 2: operation, encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- `a` input 32: multiplicand or dividend, captured with `start`.
- `b` input 32: multiplier or divisor, captured with `start`.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle pulse; HI/LO are valid from this cycle.
- `hi` output 32: product[63:32] or remainder.
- `lo` output 32: product[31:0] or quotient.
- `div_zero` output 1: divisor was zero; updated at done, held until next done.

## Operation
- FSM states: IDLE → RUN → FIX → DONE → IDLE.
- IDLE, `start`=1:
  - capture `op`.
  - capture |a| and |b|. Magnitudes are taken for signed ops only; unsigned ops capture raw values.
  - record result sign and dividend sign.
  - set cnt=0 and go to RUN.
- IDLE, `start`=0: stay in IDLE.
- `start` in any other state is ignored (no queueing).
- RUN performs one iteration per cycle, cnt 0..31. When cnt=31 it goes to FIX.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring, 33-bit partial remainder, one quotient bit per cycle.
- FIX applies sign correction, loads `hi`/`lo`/`div_zero`, then goes to DONE.
- DONE asserts `done`, then goes to IDLE.
- Arithmetic rules:
  - MULTU: full 64-bit unsigned product.
  - MULT: 64-bit two's-complement product, negated when operand signs differ.
  - DIVU: lo=a/b, hi=a%b.
  - DIV: quotient truncates toward zero. Remainder takes the sign of the dividend.
  - DIV 0x80000000 / −1: lo=0x80000000, hi=0 (wraps, no trap).
  - Divide by zero (DIV or DIVU): hi=a (raw), lo=0xFFFFFFFF, div_zero=1, no sign correction. Full latency still applies.
- Multiplies clear `div_zero` at their FIX.
- `hi`/`lo` hold their value from FIX until the next FIX.

## Timing
- Reset values: state=IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0, cnt=0.
- `rst_n` low mid-operation aborts immediately, with no done pulse and HI/LO cleared.
- Let E0 be the edge that samples `start`:
  - E1..E32: iterations.
  - E33: FIX; outputs load and `done` rises.
  - E34: back to IDLE; `done` falls and `busy` falls.
- Latency is 33 cycles, start edge to done.
- `busy` is high from E0 to E34.
- The earliest next accept is the edge after E34, i.e. E35.
- `done`, `busy`, `hi`, `lo`, `div_zero` are all registered, with no combinational path from inputs.
- Operands may change after E0 without effect.

## Structure
- Shared header `mips_defs.v` (with the existing `ALU_*` defines) holds:
  - MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - FSM state encodings MD_IDLE/MD_RUN/MD_FIX/MD_DONE.
- Single module, no sub-module: FSM, 5-bit counter, and shared 64-bit accumulator datapath in one file.
- Sign magnitude/negate logic is inline.

## Test plan
- MULTU a=10, b=10 → done exactly 33 cycles after start edge; hi=0, lo=100, div_zero=0.
- MULT a=−3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU a=100, b=7 → lo=14, hi=2. Then DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=5, b=0 → div_zero=1, hi=5, lo=0xFFFFFFFF. A following MULTU 2×3 → div_zero=0, lo=6.
- Start MULTU 10×10, pulse `start` again with new operands at cycle 5 → ignored; result still 100; exactly one done pulse.
- Start DIVU, drive `rst_n`=0 at cycle 10 → busy=0, hi=lo=0 asynchronously, no done. After release, a new op completes normally.
